parity_scan_ctrl: RTL and testbench

- Sequencer for the ROM parity-check datapath: two 8x9 banks (8 data bits + 1 parity bit each), bank-select mux and parity checker.
- Replaces the free-running ripple counter as the address source. On a start request it walks every address once, waits out the read latency, samples the checker's match bit, and accumulates an error count plus the first failing address.
- Reports completion with a done pulse and a held pass/fail verdict.

---
 rtl/parity_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_parity_scan_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_scan_ctrl.sv
// parity_scan_ctrl: walks every ROM address once, samples the parity checker after the
// read latency, and reports error count, first failing address and a pass verdict.
module parity_scan_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              match_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = (READ_LAT > 0) ? CNT_W'(READ_LAT - 1) : '0;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic              fvalid_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ERR_W-1:0]  err_d;
  logic              fvalid_d;
  logic [ADDR_W-1:0] faddr_d;
  logic              last_addr;

  // Result of this address's CHECK sample, committed only if the scan is not aborted.
  always_comb begin
    err_d     = err_q;
    fvalid_d  = fvalid_q;
    faddr_d   = faddr_q;
    last_addr = &addr_q;
    if (!match_in) begin
      if (err_q != {ERR_W{1'b1}}) begin
        err_d = err_q + 1'b1;
      end
      if (!fvalid_q) begin
        fvalid_d = 1'b1;
        faddr_d  = addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fvalid_q     <= 1'b0;
      faddr_q      <= '0;
      cnt_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            err_q        <= '0;
            fvalid_q     <= 1'b0;
            faddr_q      <= '0;
            pass_q       <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (READ_LAT == 0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (abort) begin
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            faddr_q  <= faddr_d;
            if (last_addr) begin
              state_q <= S_DONE;
            end else begin
              addr_q       <= addr_q + 1'b1;
              addr_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          // err_q already holds the final CHECK update here.
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_out        = addr_q;
  assign addr_valid      = addr_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fvalid_q;
  assign first_err_addr  = faddr_q;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Bench for parity_scan_ctrl: default build plus READ_LAT=0, READ_LAT=3 and ERR_W=3 builds.
module tb_parity_scan_ctrl;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [15:0] mask = '0;
  int n_assert = 0;
  int n_fail   = 0;
  int cyc_g    = 0;
  int start_g  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Main build (READ_LAT=1, ERR_W=5)
  logic [3:0] m_addr, m_fa, m_d1 = '0;
  logic [4:0] m_err;
  logic m_valid, m_busy, m_done, m_pass, m_fv, m_match;
  // READ_LAT=0 build
  logic [3:0] l0_addr, l0_fa;
  logic [4:0] l0_err;
  logic l0_valid, l0_busy, l0_done, l0_pass, l0_fv, l0_match;
  // READ_LAT=3 build
  logic [3:0] l3_addr, l3_fa, l3_d1 = '0, l3_d2 = '0, l3_d3 = '0;
  logic [4:0] l3_err;
  logic l3_valid, l3_busy, l3_done, l3_pass, l3_fv, l3_match;
  // ERR_W=3 build, checker tied to mismatch
  logic [3:0] e3_addr, e3_fa;
  logic [2:0] e3_err;
  logic e3_valid, e3_busy, e3_done, e3_pass, e3_fv;

  // ROM read pipelines: match reflects the address READ_LAT edges earlier.
  always @(posedge clk) begin
    m_d1  <= m_addr;
    l3_d1 <= l3_addr;
    l3_d2 <= l3_d1;
    l3_d3 <= l3_d2;
  end
  assign m_match  = ~mask[m_d1];
  assign l0_match = ~mask[l0_addr];
  assign l3_match = ~mask[l3_d3];

  int l0_done_at = -1, l3_done_at = -1, e3_done_at = -1;
  always @(negedge clk) begin
    if (l0_done) l0_done_at <= cyc_g;
    if (l3_done) l3_done_at <= cyc_g;
    if (e3_done) e3_done_at <= cyc_g;
  end

  parity_scan_ctrl #(.ADDR_W(4), .READ_LAT(1), .ERR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .match_in(m_match),
    .addr_out(m_addr), .addr_valid(m_valid), .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .first_err_valid(m_fv), .first_err_addr(m_fa));

  parity_scan_ctrl #(.ADDR_W(4), .READ_LAT(0), .ERR_W(5)) dut_l0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .match_in(l0_match),
    .addr_out(l0_addr), .addr_valid(l0_valid), .busy(l0_busy), .done(l0_done), .pass(l0_pass),
    .err_count(l0_err), .first_err_valid(l0_fv), .first_err_addr(l0_fa));

  parity_scan_ctrl #(.ADDR_W(4), .READ_LAT(3), .ERR_W(5)) dut_l3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .match_in(l3_match),
    .addr_out(l3_addr), .addr_valid(l3_valid), .busy(l3_busy), .done(l3_done), .pass(l3_pass),
    .err_count(l3_err), .first_err_valid(l3_fv), .first_err_addr(l3_fa));

  parity_scan_ctrl #(.ADDR_W(4), .READ_LAT(1), .ERR_W(3)) dut_e3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .match_in(1'b0),
    .addr_out(e3_addr), .addr_valid(e3_valid), .busy(e3_busy), .done(e3_done), .pass(e3_pass),
    .err_count(e3_err), .first_err_valid(e3_fv), .first_err_addr(e3_fa));

  typedef struct {
    int         lat_cyc;
    logic [7:0] err;
    logic       fv;
    logic [3:0] fa;
    logic       pass;
  } exp_t;

  exp_t sb_q[$];
  exp_t var_q[$];

  function automatic exp_t model(input logic [15:0] msk, input int lat, input int errmax,
                                 input logic tie0);
    exp_t e;
    e.err = '0;
    e.fv  = 1'b0;
    e.fa  = '0;
    for (int a = 0; a < 16; a++) begin
      if (tie0 || msk[a]) begin
        if (int'(e.err) < errmax) e.err = e.err + 8'd1;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fa = 4'(a);
        end
      end
    end
    e.pass    = (e.err == 8'd0);
    e.lat_cyc = 16 * (lat + 2) + 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Full scan on the main build; optionally re-pulses start at cycle restart_at.
  task automatic run_scan(input logic [15:0] msk, input int restart_at, input string tag);
    exp_t e;
    int done_seen;
    int done_cyc;
    done_seen = 0;
    done_cyc  = -1;
    mask = msk;
    sb_q.push_back(model(msk, 1, 31, 1'b0));
    start = 1'b1;
    tick();
    start   = 1'b0;
    start_g = cyc_g;
    for (int c = 0; c <= 53; c++) begin
      start = (c == restart_at);
      if (c <= 47) begin
        n_assert++;
        if (m_addr !== 4'(c / 3) || m_valid !== (c % 3 == 0) || m_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s seq c=%0d: addr=%0d valid=%0b busy=%0b, expected addr=%0d valid=%0b busy=1",
                   tag, c, m_addr, m_valid, m_busy, c / 3, (c % 3 == 0));
        end
      end
      if (m_done === 1'b1) begin
        done_seen++;
        done_cyc = c;
      end
      tick();
    end
    start = 1'b0;
    e = sb_q.pop_front();
    n_assert++;
    if (done_seen != 1 || done_cyc != e.lat_cyc) begin
      n_fail++;
      $display("FAIL %s done: pulses=%0d at c=%0d, expected 1 pulse at c=%0d",
               tag, done_seen, done_cyc, e.lat_cyc);
    end
    n_assert++;
    if (m_err !== e.err[4:0]) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d expected %0d", tag, m_err, e.err);
    end
    n_assert++;
    if (m_fv !== e.fv || m_fa !== e.fa) begin
      n_fail++;
      $display("FAIL %s first_err: got v=%0b a=%0d expected v=%0b a=%0d", tag, m_fv, m_fa, e.fv, e.fa);
    end
    n_assert++;
    if (m_pass !== e.pass || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pass/busy: got pass=%0b busy=%0b expected pass=%0b busy=0",
               tag, m_pass, m_busy, e.pass);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    n_assert++;
    if ({m_addr, m_valid, m_busy, m_done, m_pass, m_err, m_fv, m_fa} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {m_addr, m_valid, m_busy, m_done, m_pass, m_err, m_fv, m_fa});
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_assert++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0 0", m_busy, m_done);
    end
  endtask

  task automatic test_clean_scan();
    run_scan(16'h0000, -1, "clean");
  endtask

  task automatic test_faults();
    run_scan(16'h1020, -1, "faults_5_12");
  endtask

  task automatic test_abort();
    int found;
    int extra;
    found = 0;
    extra = 0;
    mask  = 16'h1020;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_addr === 4'd9 && m_valid === 1'b1) begin
        found = 1;
        break;
      end
      tick();
    end
    n_assert++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL abort_reach: addr 9 not issued within 40 cycles, got addr=%0d", m_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_assert++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%0b done=%0b pass=%0b valid=%0b expected all 0",
               m_busy, m_done, m_pass, m_valid);
    end
    n_assert++;
    if (m_err !== 5'd1 || m_fv !== 1'b1 || m_fa !== 4'd5) begin
      n_fail++;
      $display("FAIL abort_partial: err=%0d v=%0b a=%0d expected err=1 v=1 a=5", m_err, m_fv, m_fa);
    end
    for (int c = 0; c < 60; c++) begin
      if (m_done === 1'b1 || m_busy === 1'b1) extra++;
      tick();
    end
    n_assert++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, expected 0", extra);
    end
    run_scan(16'h0000, -1, "after_abort");
  endtask

  task automatic test_restart_ignored();
    run_scan(16'h0001, 20, "restart_c20");
  endtask

  task automatic test_reset_mid();
    int extra;
    extra = 0;
    mask  = 16'h1020;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    n_assert++;
    if (m_busy !== 1'b1 || m_err !== 5'd1) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%0b err=%0d expected busy=1 err=1", m_busy, m_err);
    end
    reset = 1'b0;
    #1;
    n_assert++;
    if ({m_addr, m_valid, m_busy, m_done, m_pass, m_err, m_fv, m_fa} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0",
               {m_addr, m_valid, m_busy, m_done, m_pass, m_err, m_fv, m_fa});
    end
    #2;
    reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (m_done === 1'b1 || m_busy === 1'b1) extra++;
      tick();
    end
    n_assert++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d cycles with done/busy after reset, expected 0", extra);
    end
  endtask

  task automatic test_param_builds();
    exp_t e;
    int waited;
    waited = 0;
    pulse_reset();
    var_q.push_back(model(16'h1020, 0, 31, 1'b0));
    var_q.push_back(model(16'h1020, 3, 31, 1'b0));
    var_q.push_back(model(16'h0000, 1, 7, 1'b1));
    run_scan(16'h1020, -1, "lat1_faults");
    while (l3_done_at <= start_g && waited < 60) begin
      tick();
      waited++;
    end
    e = var_q.pop_front();
    n_assert++;
    if (l0_done_at - start_g != e.lat_cyc) begin
      n_fail++;
      $display("FAIL lat0_done: got c=%0d expected c=%0d", l0_done_at - start_g, e.lat_cyc);
    end
    n_assert++;
    if (l0_err !== e.err[4:0] || l0_fv !== e.fv || l0_fa !== e.fa || l0_pass !== e.pass) begin
      n_fail++;
      $display("FAIL lat0_result: err=%0d v=%0b a=%0d pass=%0b expected err=%0d v=%0b a=%0d pass=%0b",
               l0_err, l0_fv, l0_fa, l0_pass, e.err, e.fv, e.fa, e.pass);
    end
    e = var_q.pop_front();
    n_assert++;
    if (l3_done_at - start_g != e.lat_cyc) begin
      n_fail++;
      $display("FAIL lat3_done: got c=%0d expected c=%0d", l3_done_at - start_g, e.lat_cyc);
    end
    n_assert++;
    if (l3_err !== e.err[4:0] || l3_fv !== e.fv || l3_fa !== e.fa || l3_pass !== e.pass) begin
      n_fail++;
      $display("FAIL lat3_result: err=%0d v=%0b a=%0d pass=%0b expected err=%0d v=%0b a=%0d pass=%0b",
               l3_err, l3_fv, l3_fa, l3_pass, e.err, e.fv, e.fa, e.pass);
    end
    e = var_q.pop_front();
    n_assert++;
    if (e3_done_at - start_g != e.lat_cyc) begin
      n_fail++;
      $display("FAIL errw3_done: got c=%0d expected c=%0d", e3_done_at - start_g, e.lat_cyc);
    end
    n_assert++;
    if (e3_err !== e.err[2:0] || e3_fv !== e.fv || e3_fa !== e.fa || e3_pass !== e.pass) begin
      n_fail++;
      $display("FAIL errw3_sat: err=%0d v=%0b a=%0d pass=%0b expected err=%0d v=%0b a=%0d pass=%0b",
               e3_err, e3_fv, e3_fa, e3_pass, e.err, e.fv, e.fa, e.pass);
    end
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_faults();
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    test_param_builds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
